// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: decodes the held IR fields and drives
// datapath selects/enables per state, with a memory stall watchdog and a sticky trap.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Fault
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT_M1 =
    (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mem_state;
  logic             w_wait;
  logic             w_timeout;
  logic             w_br_legal;
  logic [2:0]       w_alu_dec;
  logic [2:0]       w_imm_dec;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                       (r_state == S_MEMWRITE);
  assign w_wait      = w_mem_state && !MemReady;
  // The limit is hit by the stall cycle that would bring the count to MEM_TIMEOUT.
  assign w_timeout   = (MEM_TIMEOUT != 0) && w_wait && (r_cnt == LIMIT_M1);
  assign w_br_legal  = (funct3[2:1] == 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wait && (w_state_next == r_state))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (MemReady)       w_state_next = S_DECODE;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE:  w_state_next = S_MEMADR;
          OP_RTYPE:  w_state_next = S_EXECR;
          OP_ITYPE:  w_state_next = S_EXECI;
          OP_BRANCH: w_state_next = S_BRANCH;
          OP_JAL:    w_state_next = S_JAL;
          default:   w_state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (MemReady)       w_state_next = S_MEMWB;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_MEMWB:    w_state_next = S_FETCH;
      S_MEMWRITE: begin
        if (MemReady)       w_state_next = S_FETCH;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_EXECR,
      S_EXECI:    w_state_next = S_ALUWB;
      S_ALUWB:    w_state_next = S_FETCH;
      S_BRANCH:   w_state_next = w_br_legal ? S_FETCH : S_TRAP;
      S_JAL:      w_state_next = S_ALUWB;
      S_TRAP:     w_state_next = S_TRAP;
      default:    w_state_next = S_FETCH;
    endcase
  end

  // sra/srai fall through to srl; sltu shares the slt encoding.
  always_comb begin
    w_alu_dec = 3'b000;
    case (funct3)
      3'b000:  w_alu_dec = ((r_state == S_EXECR) && funct7b5) ? 3'b001 : 3'b000;
      3'b001:  w_alu_dec = 3'b110;
      3'b010,
      3'b011:  w_alu_dec = 3'b101;
      3'b100:  w_alu_dec = 3'b100;
      3'b101:  w_alu_dec = 3'b111;
      3'b110:  w_alu_dec = 3'b011;
      3'b111:  w_alu_dec = 3'b010;
      default: w_alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    w_imm_dec = 3'b000;
    case (op)
      OP_STORE:  w_imm_dec = 3'b001;
      OP_BRANCH: w_imm_dec = 3'b010;
      OP_JAL:    w_imm_dec = 3'b011;
      default:   w_imm_dec = 3'b000;
    endcase
  end

  always_comb begin
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 3'b000;
    ALUControl = 3'b000;
    Fault      = 1'b0;
    // Reset gates every output so the FETCH request is not visible while held in reset.
    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = MemReady;
          PCWrite   = MemReady;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = w_imm_dec;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_LOAD) ? 3'b000 : 3'b001;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = w_alu_dec;
        end
        S_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = w_alu_dec;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = 3'b001;
          ImmSrc     = 3'b010;
          PCWrite    = w_br_legal && (Zero ^ funct3[0]);
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        S_TRAP: begin
          Fault = 1'b1;
        end
        default: begin
          Fault = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction state walks checked via
// the packed control word, plus watchdog and reset-abort scenarios on a MEM_TIMEOUT=4 copy.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'h00;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Fault}
  wire [18:0] w_obs;
  wire [18:0] w_obs4;

  int checks = 0;
  int errors = 0;

  logic [18:0] FETCH_RDY, FETCH_STL, DEC_I, DEC_S, DEC_B, DEC_J;
  logic [18:0] MEMADR_LW, MEMADR_SW, MEMRD, MEMWB, MEMWR, ALUWB, JALW, TRAPW;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady),
    .MemReq(w_obs[18]), .MemWrite(w_obs[17]), .AdrSrc(w_obs[16]), .IRWrite(w_obs[15]),
    .PCWrite(w_obs[14]), .RegWrite(w_obs[13]), .ResultSrc(w_obs[12:11]),
    .ALUSrcA(w_obs[10:9]), .ALUSrcB(w_obs[8:7]), .ImmSrc(w_obs[6:4]),
    .ALUControl(w_obs[3:1]), .Fault(w_obs[0])
  );

  multicycle_controller #(.MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady),
    .MemReq(w_obs4[18]), .MemWrite(w_obs4[17]), .AdrSrc(w_obs4[16]), .IRWrite(w_obs4[15]),
    .PCWrite(w_obs4[14]), .RegWrite(w_obs4[13]), .ResultSrc(w_obs4[12:11]),
    .ALUSrcA(w_obs4[10:9]), .ALUSrcB(w_obs4[8:7]), .ImmSrc(w_obs4[6:4]),
    .ALUControl(w_obs4[3:1]), .Fault(w_obs4[0])
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next cycle, drive that cycle's inputs, then let outputs settle.
  task automatic cyc(input logic mr, input logic z);
    @(posedge clk);
    #1;
    MemReady = mr;
    Zero     = z;
    #1;
  endtask

  // Leaves the DUTs in their first post-reset FETCH cycle with MemReady=mr.
  task automatic do_reset(input logic mr);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    MemReady = 1'b0;
    Zero     = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    MemReady = mr;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    MemReady = 1'b1;
    Zero     = 1'b1;
    #1;
    checks++;
    if (w_obs !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", w_obs, 19'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (w_obs !== FETCH_RDY) begin
      errors++;
      $display("FAIL reset_first_fetch: got %h want %h", w_obs, FETCH_RDY);
    end
  endtask

  task automatic test_lw();
    logic [18:0] ex [6];
    ex = '{FETCH_RDY, DEC_I, MEMADR_LW, MEMRD, MEMWB, FETCH_STL};
    op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc((i == 5) ? 1'b0 : 1'b1, 1'b0);
      checks++;
      if (w_obs !== ex[i]) begin
        errors++;
        $display("FAIL lw_cycle%0d: got %h want %h", i, w_obs, ex[i]);
      end
    end
  endtask

  task automatic test_sw_stall();
    logic [18:0] ex [8];
    logic [7:0]  mrv;
    ex  = '{FETCH_RDY, DEC_S, MEMADR_SW, MEMWR, MEMWR, MEMWR, MEMWR, FETCH_STL};
    mrv = 8'b0100_0111; // bit i = MemReady in cycle i
    op = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc(mrv[i], 1'b0);
      checks++;
      if (w_obs !== ex[i]) begin
        errors++;
        $display("FAIL sw_stall_cycle%0d: got %h want %h", i, w_obs, ex[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3v [4];
    logic        zv  [4];
    logic        pwv [4];
    logic [18:0] next_ex;
    f3v = '{3'b000, 3'b001, 3'b000, 3'b100};
    zv  = '{1'b1,   1'b1,   1'b0,   1'b1};
    pwv = '{1'b1,   1'b0,   1'b0,   1'b0};
    for (int k = 0; k < 4; k++) begin
      op = OP_B; funct3 = f3v[k]; funct7b5 = 1'b0;
      do_reset(1'b1);
      cyc(1'b0, 1'b0);
      checks++;
      if (w_obs !== DEC_B) begin
        errors++;
        $display("FAIL branch%0d_decode: got %h want %h", k, w_obs, DEC_B);
      end
      cyc(1'b0, zv[k]);
      checks++;
      if (w_obs !== {4'b0000, pwv[k], 1'b0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 1'b0}) begin
        errors++;
        $display("FAIL branch%0d_exec: got %h want %h", k, w_obs,
                 {4'b0000, pwv[k], 1'b0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 1'b0});
      end
      next_ex = (k == 3) ? TRAPW : FETCH_STL;
      cyc(1'b0, 1'b0);
      checks++;
      if (w_obs !== next_ex) begin
        errors++;
        $display("FAIL branch%0d_next: got %h want %h", k, w_obs, next_ex);
      end
    end
  endtask

  task automatic test_rtype();
    logic [2:0] f3v  [2];
    logic [2:0] aluv [2];
    f3v  = '{3'b000, 3'b101};
    aluv = '{3'b001, 3'b111};
    for (int k = 0; k < 2; k++) begin
      op = OP_R; funct3 = f3v[k]; funct7b5 = 1'b1;
      do_reset(1'b1);
      cyc(1'b0, 1'b0);
      checks++;
      if (w_obs !== DEC_I) begin
        errors++;
        $display("FAIL rtype%0d_decode: got %h want %h", k, w_obs, DEC_I);
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (w_obs !== {6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, aluv[k], 1'b0}) begin
        errors++;
        $display("FAIL rtype%0d_exec: got %h want %h", k, w_obs,
                 {6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, aluv[k], 1'b0});
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (w_obs !== ALUWB) begin
        errors++;
        $display("FAIL rtype%0d_wb: got %h want %h", k, w_obs, ALUWB);
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (w_obs !== FETCH_STL) begin
        errors++;
        $display("FAIL rtype%0d_refetch: got %h want %h", k, w_obs, FETCH_STL);
      end
    end
  endtask

  task automatic test_itype_alu();
    logic [2:0] aluv [8];
    aluv = '{3'b000, 3'b110, 3'b101, 3'b101, 3'b100, 3'b111, 3'b011, 3'b010};
    for (int k = 0; k < 8; k++) begin
      op = OP_I; funct3 = 3'(k); funct7b5 = 1'b1;
      do_reset(1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      checks++;
      if (w_obs !== {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, aluv[k], 1'b0}) begin
        errors++;
        $display("FAIL itype_f3_%0d: got %h want %h", k, w_obs,
                 {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, aluv[k], 1'b0});
      end
    end
  endtask

  task automatic test_jal();
    logic [18:0] ex [5];
    ex = '{FETCH_RDY, DEC_J, JALW, ALUWB, FETCH_STL};
    op = OP_J; funct3 = 3'b000; funct7b5 = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc(1'b0, 1'b0);
      checks++;
      if (w_obs !== ex[i]) begin
        errors++;
        $display("FAIL jal_cycle%0d: got %h want %h", i, w_obs, ex[i]);
      end
    end
  endtask

  task automatic test_trap();
    op = 7'h7F; funct3 = 3'b000; funct7b5 = 1'b0;
    do_reset(1'b1);
    cyc(1'b0, 1'b0);
    checks++;
    if (w_obs !== DEC_I) begin
      errors++;
      $display("FAIL trap_decode: got %h want %h", w_obs, DEC_I);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1);
      checks++;
      if (w_obs !== TRAPW) begin
        errors++;
        $display("FAIL trap_sticky%0d: got %h want %h", i, w_obs, TRAPW);
      end
    end
    do_reset(1'b1);
    checks++;
    if (w_obs !== FETCH_RDY) begin
      errors++;
      $display("FAIL trap_cleared_by_reset: got %h want %h", w_obs, FETCH_RDY);
    end
  endtask

  task automatic test_timeout();
    op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0;
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) cyc(1'b0, 1'b0);
      checks++;
      if (w_obs4 !== FETCH_STL) begin
        errors++;
        $display("FAIL timeout_stall%0d: got %h want %h", i, w_obs4, FETCH_STL);
      end
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (w_obs4 !== TRAPW) begin
      errors++;
      $display("FAIL timeout_trap: got %h want %h", w_obs4, TRAPW);
    end
    checks++;
    if (w_obs !== FETCH_STL) begin
      errors++;
      $display("FAIL timeout_default_still_waiting: got %h want %h", w_obs, FETCH_STL);
    end
    // MemReady arriving on the limit cycle completes the fetch.
    do_reset(1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    checks++;
    if (w_obs4 !== FETCH_RDY) begin
      errors++;
      $display("FAIL timeout_limit_ready: got %h want %h", w_obs4, FETCH_RDY);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (w_obs4 !== DEC_I) begin
      errors++;
      $display("FAIL timeout_limit_decode: got %h want %h", w_obs4, DEC_I);
    end
  endtask

  task automatic test_reset_mid_write();
    op = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0;
    do_reset(1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (w_obs4 !== MEMWR) begin
      errors++;
      $display("FAIL abort_pre_write: got %h want %h", w_obs4, MEMWR);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (w_obs4 !== 19'h0) begin
      errors++;
      $display("FAIL abort_async_drop: got %h want %h", w_obs4, 19'h0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    MemReady = 1'b0;
    #1;
    // A cleared counter needs four fresh stall cycles before trapping.
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) cyc(1'b0, 1'b0);
      checks++;
      if (w_obs4 !== FETCH_STL) begin
        errors++;
        $display("FAIL abort_refetch_stall%0d: got %h want %h", i, w_obs4, FETCH_STL);
      end
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (w_obs4 !== TRAPW) begin
      errors++;
      $display("FAIL abort_counter_trap: got %h want %h", w_obs4, TRAPW);
    end
  endtask

  initial begin
    FETCH_RDY = {6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0};
    FETCH_STL = {6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0};
    DEC_I     = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0};
    DEC_S     = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b001, 3'b000, 1'b0};
    DEC_B     = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 1'b0};
    DEC_J     = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b011, 3'b000, 1'b0};
    MEMADR_LW = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0};
    MEMADR_SW = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 1'b0};
    MEMRD     = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
    MEMWB     = {6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
    MEMWR     = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
    ALUWB     = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
    JALW      = {6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0};
    TRAPW     = 19'h00001;

    test_reset();
    test_lw();
    test_sw_stall();
    test_branch();
    test_rtype();
    test_itype_alu();
    test_jal();
    test_trap();
    test_timeout();
    test_reset_mid_write();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
